// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side controller for a show-ahead sync_fifo. A request (i_start, i_len)
//   drains exactly i_len words from the FIFO and presents them on a valid/ready
//   stream, with o_last on the final word. A 2-entry output buffer allows one pop
//   per cycle at full throughput. o_fifo_pop is computed only from registers,
//   i_fifo_not_empty and the abort override, so it does not depend on i_ready.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_start, i_len          burst request and length (sampled in IDLE only)
//   i_abort                 terminate burst, discard buffered words, no o_done
//   o_busy, o_done          busy in RUN/DRAIN; one-cycle pulse after burst ends
//   i_fifo_rdata            FIFO head word (show-ahead)
//   i_fifo_not_empty        FIFO holds at least one word
//   o_fifo_pop              FIFO pop; i_fifo_rdata is captured in the same cycle
//   o_data, o_valid, o_last stream output (head of the output buffer)
//   i_ready                 stream ready
module fifo_burst_reader #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned LEN_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_abort,
   output logic             o_busy,
   output logic             o_done,
   input  logic [WIDTH-1:0] i_fifo_rdata,
   input  logic             i_fifo_not_empty,
   output logic             o_fifo_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_last
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] pops_left_q, pops_left_d;
   logic [1:0]       buf_cnt_q, buf_cnt_d;
   logic [WIDTH-1:0] hd_data_q, hd_data_d;
   logic [WIDTH-1:0] tl_data_q, tl_data_d;
   logic             hd_last_q, hd_last_d;
   logic             tl_last_q, tl_last_d;
   logic             done_q, done_d;

   logic             abort_act;
   logic             pop_ok;
   logic             xfer;
   logic             wr_sel;

   // Abort only acts while a burst is in progress.
   assign abort_act  = i_abort && (state_q != StIdle);
   assign pop_ok     = (state_q == StRun) && i_fifo_not_empty &&
                       (pops_left_q != '0) && (buf_cnt_q != 2'd2);
   assign o_fifo_pop = pop_ok && !abort_act;

   assign o_valid = (buf_cnt_q != 2'd0);
   assign o_data  = hd_data_q;
   assign o_last  = o_valid && hd_last_q;
   assign o_busy  = (state_q != StIdle);
   assign o_done  = done_q;
   assign xfer    = o_valid && i_ready;

   // Slot written by a pop after any same-cycle shift: cnt0 -> head,
   // cnt1 -> tail (head if the head leaves), cnt2 with transfer -> tail.
   assign wr_sel = buf_cnt_q[0] ^ xfer;

   always_comb begin
      state_d     = state_q;
      pops_left_d = pops_left_q;
      buf_cnt_d   = buf_cnt_q;
      hd_data_d   = hd_data_q;
      tl_data_d   = tl_data_q;
      hd_last_d   = hd_last_q;
      tl_last_d   = tl_last_q;
      done_d      = 1'b0;

      // Output buffer: shift on transfer, then write the popped word.
      if (xfer) begin
         hd_data_d = tl_data_q;
         hd_last_d = tl_last_q;
      end
      if (o_fifo_pop) begin
         pops_left_d = pops_left_q - LEN_W'(1);
         if (wr_sel) begin
            tl_data_d = i_fifo_rdata;
            tl_last_d = (pops_left_q == LEN_W'(1));
         end else begin
            hd_data_d = i_fifo_rdata;
            hd_last_d = (pops_left_q == LEN_W'(1));
         end
      end
      buf_cnt_d = buf_cnt_q + {1'b0, o_fifo_pop} - {1'b0, xfer};

      case (state_q)
         StIdle: begin
            if (i_start) begin
               if (i_len != '0) begin
                  state_d     = StRun;
                  pops_left_d = i_len;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         StRun: begin
            // The last word can leave while still in RUN at full throughput.
            if (xfer && o_last) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else if (pops_left_q == '0) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (xfer && o_last) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (abort_act) begin
         state_d     = StIdle;
         pops_left_d = '0;
         buf_cnt_d   = 2'd0;
         done_d      = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= StIdle;
         pops_left_q <= '0;
         buf_cnt_q   <= 2'd0;
         hd_data_q   <= '0;
         tl_data_q   <= '0;
         hd_last_q   <= 1'b0;
         tl_last_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pops_left_q <= pops_left_d;
         buf_cnt_q   <= buf_cnt_d;
         hd_data_q   <= hd_data_d;
         tl_data_q   <= tl_data_d;
         hd_last_q   <= hd_last_d;
         tl_last_q   <= tl_last_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned LEN_W = 8;

   logic             clk = 1'b0;
   logic             i_rst, i_start, i_abort, i_ready, i_fifo_not_empty;
   logic [LEN_W-1:0] i_len;
   logic [WIDTH-1:0] i_fifo_rdata;
   logic             o_busy, o_done, o_fifo_pop, o_valid, o_last;
   logic [WIDTH-1:0] o_data;

   always #5 clk = ~clk;

   fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len), .i_abort(i_abort),
      .o_busy(o_busy), .o_done(o_done), .i_fifo_rdata(i_fifo_rdata),
      .i_fifo_not_empty(i_fifo_not_empty), .o_fifo_pop(o_fifo_pop), .o_data(o_data),
      .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Environment FIFO (show-ahead) and stream monitor.
   logic [WIDTH-1:0] fifo_q[$];
   logic [WIDTH-1:0] obs_d[$];
   logic             obs_l[$];
   int cyc, mon_pops, mon_done, mon_done_cyc, mon_first_pop, mon_first_valid;
   int mon_valid_cnt, mon_busy_cnt, mon_hold_viol, mon_pop_empty, mon_last_bad;
   logic mon_valid, mon_busy, mon_pop, prev_stall;
   logic [WIDTH-1:0] mon_data, prev_data;

   task automatic drive_fifo();
      i_fifo_not_empty = (fifo_q.size() != 0);
      i_fifo_rdata     = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   task automatic push_word(input logic [WIDTH-1:0] w);
      fifo_q.push_back(w);
      drive_fifo();
   endtask

   task automatic clr_mon();
      cyc = 0; mon_pops = 0; mon_done = 0; mon_done_cyc = -1; mon_first_pop = -1;
      mon_first_valid = -1; mon_valid_cnt = 0; mon_busy_cnt = 0; mon_hold_viol = 0;
      mon_pop_empty = 0; mon_last_bad = 0; prev_stall = 1'b0;
      obs_d.delete(); obs_l.delete();
   endtask

   // One clock cycle: sample outputs mid-cycle, then apply the FIFO pop after the edge.
   task automatic cycle();
      @(negedge clk);
      mon_valid = o_valid; mon_busy = o_busy; mon_pop = o_fifo_pop; mon_data = o_data;
      if (o_fifo_pop) begin
         mon_pops++;
         if (mon_first_pop < 0) mon_first_pop = cyc;
      end
      if (o_valid) begin
         mon_valid_cnt++;
         if (mon_first_valid < 0) mon_first_valid = cyc;
      end
      if (o_busy) mon_busy_cnt++;
      if (o_done) begin mon_done++; mon_done_cyc = cyc; end
      if (o_last && !o_valid) mon_last_bad++;
      if (prev_stall && o_valid && (o_data !== prev_data)) mon_hold_viol++;
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      if (o_valid && i_ready) begin obs_d.push_back(o_data); obs_l.push_back(o_last); end
      @(posedge clk);
      #1;
      if (mon_pop) begin
         if (fifo_q.size() == 0) mon_pop_empty++;
         else void'(fifo_q.pop_front());
      end
      drive_fifo();
      cyc++;
   endtask

   task automatic start_burst(input int len);
      i_start = 1'b1;
      i_len   = LEN_W'(len);
      cycle();
      i_start = 1'b0;
   endtask

   task automatic run_until_done(input int limit);
      int n = 0;
      while (mon_done == 0 && n < limit) begin cycle(); n++; end
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0; i_len = '0;
      fifo_q.delete(); drive_fifo(); clr_mon();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", o_busy); end
      n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", o_done); end
      n_cmp++; if (o_fifo_pop !== 1'b0) begin n_err++; $display("FAIL reset_pop got %b want 0", o_fifo_pop); end
      n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", o_valid); end
      n_cmp++; if (o_last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", o_last); end
      n_cmp++; if (o_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", o_data); end
      i_rst = 1'b0;
      repeat (2) cycle();
      n_cmp++; if (mon_busy_cnt !== 0) begin n_err++; $display("FAIL reset_idle busy cycles %0d want 0", mon_busy_cnt); end
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] a[$];
      clr_mon(); fifo_q.delete();
      for (int i = 0; i < 6; i++) begin a.push_back(WIDTH'($urandom)); push_word(a[i]); end
      i_ready = 1'b1;
      start_burst(4);
      run_until_done(30);
      cycle();
      n_cmp++; if (mon_pops !== 4) begin n_err++; $display("FAIL basic_pops got %0d want 4", mon_pops); end
      n_cmp++; if (mon_first_pop !== 1) begin n_err++; $display("FAIL basic_first_pop got %0d want 1", mon_first_pop); end
      n_cmp++; if (mon_first_valid !== 2) begin n_err++; $display("FAIL basic_first_valid got %0d want 2", mon_first_valid); end
      n_cmp++; if (mon_valid_cnt !== 4) begin n_err++; $display("FAIL basic_valid_cycles got %0d want 4", mon_valid_cnt); end
      n_cmp++; if (mon_done !== 1) begin n_err++; $display("FAIL basic_done_count got %0d want 1", mon_done); end
      n_cmp++; if (mon_done_cyc !== 6) begin n_err++; $display("FAIL basic_done_cycle got %0d want 6", mon_done_cyc); end
      n_cmp++; if (obs_d.size() !== 4) begin n_err++; $display("FAIL basic_xfers got %0d want 4", obs_d.size()); end
      for (int i = 0; i < obs_d.size() && i < 4; i++) begin
         n_cmp++; if (obs_d[i] !== a[i]) begin n_err++; $display("FAIL basic_data[%0d] got %h want %h", i, obs_d[i], a[i]); end
         n_cmp++; if (obs_l[i] !== (i == 3)) begin n_err++; $display("FAIL basic_last[%0d] got %b want %b", i, obs_l[i], (i == 3)); end
      end
      n_cmp++; if (fifo_q.size() !== 2) begin n_err++; $display("FAIL basic_fifo_left got %0d want 2", fifo_q.size()); end
      if (fifo_q.size() == 2) begin
         n_cmp++; if (fifo_q[0] !== a[4] || fifo_q[1] !== a[5]) begin
            n_err++; $display("FAIL basic_fifo_words got %h %h want %h %h", fifo_q[0], fifo_q[1], a[4], a[5]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] a[$];
      clr_mon(); fifo_q.delete();
      for (int i = 0; i < 6; i++) begin a.push_back(WIDTH'($urandom)); push_word(a[i]); end
      i_ready = 1'b1;
      start_burst(4);
      cycle();
      i_ready = 1'b0;
      repeat (5) cycle();
      n_cmp++; if (mon_pops !== 2) begin n_err++; $display("FAIL bp_pops got %0d want 2", mon_pops); end
      n_cmp++; if (mon_pop !== 1'b0) begin n_err++; $display("FAIL bp_pop_low got %b want 0", mon_pop); end
      n_cmp++; if (mon_data !== a[0]) begin n_err++; $display("FAIL bp_hold_data got %h want %h", mon_data, a[0]); end
      i_ready = 1'b1;
      run_until_done(30);
      n_cmp++; if (mon_hold_viol !== 0) begin n_err++; $display("FAIL bp_hold_changes got %0d want 0", mon_hold_viol); end
      n_cmp++; if (obs_d.size() !== 4) begin n_err++; $display("FAIL bp_xfers got %0d want 4", obs_d.size()); end
      for (int i = 0; i < obs_d.size() && i < 4; i++) begin
         n_cmp++; if (obs_d[i] !== a[i] || obs_l[i] !== (i == 3)) begin
            n_err++; $display("FAIL bp_word[%0d] got %h/%b want %h/%b", i, obs_d[i], obs_l[i], a[i], (i == 3));
         end
      end
   endtask

   task automatic test_empty();
      logic [WIDTH-1:0] b[$];
      clr_mon(); fifo_q.delete(); drive_fifo();
      i_ready = 1'b1;
      start_burst(3);
      repeat (9) cycle();
      n_cmp++; if (mon_pops !== 0) begin n_err++; $display("FAIL empty_pops got %0d want 0", mon_pops); end
      n_cmp++; if (mon_valid_cnt !== 0) begin n_err++; $display("FAIL empty_valid got %0d want 0", mon_valid_cnt); end
      n_cmp++; if (mon_busy !== 1'b1) begin n_err++; $display("FAIL empty_busy got %b want 1", mon_busy); end
      for (int i = 0; i < 3; i++) begin
         b.push_back(WIDTH'($urandom));
         push_word(b[i]);
         cycle();
      end
      run_until_done(30);
      n_cmp++; if (mon_done !== 1) begin n_err++; $display("FAIL empty_done got %0d want 1", mon_done); end
      n_cmp++; if (obs_d.size() !== 3) begin n_err++; $display("FAIL empty_xfers got %0d want 3", obs_d.size()); end
      for (int i = 0; i < obs_d.size() && i < 3; i++) begin
         n_cmp++; if (obs_d[i] !== b[i] || obs_l[i] !== (i == 2)) begin
            n_err++; $display("FAIL empty_word[%0d] got %h/%b want %h/%b", i, obs_d[i], obs_l[i], b[i], (i == 2));
         end
      end
   endtask

   task automatic test_zero_len();
      clr_mon(); fifo_q.delete();
      push_word(WIDTH'($urandom)); push_word(WIDTH'($urandom));
      i_ready = 1'b1;
      start_burst(0);
      repeat (3) cycle();
      n_cmp++; if (mon_done !== 1) begin n_err++; $display("FAIL zero_done_count got %0d want 1", mon_done); end
      n_cmp++; if (mon_done_cyc !== 1) begin n_err++; $display("FAIL zero_done_cycle got %0d want 1", mon_done_cyc); end
      n_cmp++; if (mon_busy_cnt !== 0) begin n_err++; $display("FAIL zero_busy got %0d want 0", mon_busy_cnt); end
      n_cmp++; if (mon_pops !== 0) begin n_err++; $display("FAIL zero_pops got %0d want 0", mon_pops); end
   endtask

   task automatic test_abort();
      logic [WIDTH-1:0] a[$];
      int n = 0;
      clr_mon(); fifo_q.delete();
      for (int i = 0; i < 12; i++) begin a.push_back(WIDTH'($urandom)); push_word(a[i]); end
      i_ready = 1'b1;
      start_burst(8);
      while (obs_d.size() < 3 && n < 30) begin cycle(); n++; end
      n_cmp++; if (obs_d.size() !== 3) begin n_err++; $display("FAIL abort_reach3 got %0d want 3", obs_d.size()); end
      // Full throughput: pops in cycles 1..4 by the third transfer.
      n_cmp++; if (mon_pops !== 4) begin n_err++; $display("FAIL abort_pops_before got %0d want 4", mon_pops); end
      i_abort = 1'b1; i_ready = 1'b0;
      cycle();
      n_cmp++; if (mon_pop !== 1'b0) begin n_err++; $display("FAIL abort_pop_forced got %b want 0", mon_pop); end
      i_abort = 1'b0; i_ready = 1'b1;
      cycle();
      n_cmp++; if (mon_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid_next got %b want 0", mon_valid); end
      n_cmp++; if (mon_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy_next got %b want 0", mon_busy); end
      repeat (5) cycle();
      n_cmp++; if (mon_pops !== 4) begin n_err++; $display("FAIL abort_pops_after got %0d want 4", mon_pops); end
      n_cmp++; if (mon_done !== 0) begin n_err++; $display("FAIL abort_done got %0d want 0", mon_done); end
      for (int i = 0; i < obs_d.size() && i < 3; i++) begin
         n_cmp++; if (obs_d[i] !== a[i] || obs_l[i] !== 1'b0) begin
            n_err++; $display("FAIL abort_word[%0d] got %h/%b want %h/0", i, obs_d[i], obs_l[i], a[i]);
         end
      end
      clr_mon();
      start_burst(2);
      run_until_done(30);
      n_cmp++; if (obs_d.size() !== 2) begin n_err++; $display("FAIL abort_next_xfers got %0d want 2", obs_d.size()); end
      for (int i = 0; i < obs_d.size() && i < 2; i++) begin
         n_cmp++; if (obs_d[i] !== a[4+i] || obs_l[i] !== (i == 1)) begin
            n_err++; $display("FAIL abort_next_word[%0d] got %h/%b want %h/%b", i, obs_d[i], obs_l[i], a[4+i], (i == 1));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [WIDTH-1:0] a[$];
      clr_mon(); fifo_q.delete();
      for (int i = 0; i < 10; i++) begin a.push_back(WIDTH'($urandom)); push_word(a[i]); end
      i_ready = 1'b1;
      start_burst(6);
      repeat (2) cycle();
      #2;
      i_rst = 1'b1;
      #1;
      n_cmp++; if ({o_busy, o_done, o_fifo_pop, o_valid, o_last} !== 5'b0) begin
         n_err++; $display("FAIL rstmid_flags got %b want 00000", {o_busy, o_done, o_fifo_pop, o_valid, o_last});
      end
      n_cmp++; if (o_data !== '0) begin n_err++; $display("FAIL rstmid_data got %h want 0", o_data); end
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      clr_mon();
      cycle();
      n_cmp++; if (mon_busy !== 1'b0 || mon_pop !== 1'b0) begin
         n_err++; $display("FAIL rstmid_idle busy %b pop %b want 0 0", mon_busy, mon_pop);
      end
      clr_mon();
      start_burst(2);
      run_until_done(30);
      // Pops happened in cycles 1 and 2 before reset, so a[2], a[3] come next.
      n_cmp++; if (obs_d.size() !== 2) begin n_err++; $display("FAIL rstmid_xfers got %0d want 2", obs_d.size()); end
      for (int i = 0; i < obs_d.size() && i < 2; i++) begin
         n_cmp++; if (obs_d[i] !== a[2+i] || obs_l[i] !== (i == 1)) begin
            n_err++; $display("FAIL rstmid_word[%0d] got %h/%b want %h/%b", i, obs_d[i], obs_l[i], a[2+i], (i == 1));
         end
      end
   endtask

   task automatic test_max_len();
      logic [WIDTH-1:0] a[$];
      int n = 0;
      int lasts = 0;
      int bad = 0;
      clr_mon(); fifo_q.delete();
      for (int i = 0; i < 256; i++) begin a.push_back(WIDTH'($urandom)); push_word(a[i]); end
      i_ready = 1'b1;
      start_burst(255);
      while (mon_done == 0 && n < 3000) begin
         i_ready = ($urandom_range(0, 3) != 0);
         cycle();
         n++;
      end
      i_ready = 1'b1;
      n_cmp++; if (mon_done !== 1) begin n_err++; $display("FAIL max_done got %0d want 1", mon_done); end
      n_cmp++; if (mon_pops !== 255) begin n_err++; $display("FAIL max_pops got %0d want 255", mon_pops); end
      n_cmp++; if (obs_d.size() !== 255) begin n_err++; $display("FAIL max_xfers got %0d want 255", obs_d.size()); end
      for (int i = 0; i < obs_d.size(); i++) begin
         if (obs_l[i]) lasts++;
         if (i < 255 && obs_d[i] !== a[i]) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL max_data_errors got %0d want 0", bad); end
      n_cmp++; if (lasts !== 1) begin n_err++; $display("FAIL max_last_count got %0d want 1", lasts); end
      if (obs_l.size() == 255) begin
         n_cmp++; if (obs_l[254] !== 1'b1) begin n_err++; $display("FAIL max_last_pos got %b want 1", obs_l[254]); end
      end
      n_cmp++; if (fifo_q.size() !== 1) begin n_err++; $display("FAIL max_fifo_left got %0d want 1", fifo_q.size()); end
      n_cmp++; if (mon_hold_viol !== 0 || mon_last_bad !== 0 || mon_pop_empty !== 0) begin
         n_err++; $display("FAIL max_protocol hold %0d last %0d popempty %0d want 0 0 0",
                           mon_hold_viol, mon_last_bad, mon_pop_empty);
      end
   endtask

   task automatic test_back_to_back();
      fifo_q.delete(); drive_fifo();
      for (int b = 0; b < 5; b++) begin
         logic [WIDTH-1:0] w[$];
         int len = $urandom_range(1, 12);
         int pushed = 0;
         int n = 0;
         for (int i = 0; i < len; i++) w.push_back(WIDTH'($urandom));
         clr_mon();
         i_start = 1'b1; i_len = LEN_W'(len);
         while (mon_done == 0 && n < 500) begin
            if (pushed < len && $urandom_range(0, 1) == 1) begin push_word(w[pushed]); pushed++; end
            i_ready = ($urandom_range(0, 2) != 0);
            cycle();
            i_start = 1'b0;
            n++;
         end
         i_ready = 1'b1;
         n_cmp++; if (mon_done !== 1) begin n_err++; $display("FAIL b2b[%0d]_done got %0d want 1", b, mon_done); end
         n_cmp++; if (obs_d.size() !== len) begin n_err++; $display("FAIL b2b[%0d]_xfers got %0d want %0d", b, obs_d.size(), len); end
         for (int i = 0; i < obs_d.size() && i < len; i++) begin
            n_cmp++; if (obs_d[i] !== w[i] || obs_l[i] !== (i == len - 1)) begin
               n_err++; $display("FAIL b2b[%0d]_word[%0d] got %h/%b want %h/%b", b, i, obs_d[i], obs_l[i], w[i], (i == len - 1));
            end
         end
         n_cmp++; if (mon_hold_viol !== 0 || mon_last_bad !== 0 || mon_pop_empty !== 0) begin
            n_err++; $display("FAIL b2b[%0d]_protocol hold %0d last %0d popempty %0d want 0 0 0",
                              b, mon_hold_viol, mon_last_bad, mon_pop_empty);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_empty();
      test_zero_len();
      test_abort();
      test_reset_mid();
      test_max_len();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
